uart_reg_host: RTL
==================

// Module: uart_reg_host
// PURPOSE
//   Reg-bus initiator for the 8-bit UART register interface (reg_cs/reg_wr/reg_addr/
//   reg_wdata/reg_be, reg_rdata/reg_ack). Turns one-at-a-time commands from a
//   valid/ready port into single bus cycles and returns read data/status on a
//   valid/ready response port. Sits between a local sequencer and uart_core's reg bus.
//   Aborts a bus cycle with an error if no ack arrives in time.
// PARAMETERS
//   TO_CYC  16'd255  cycles reg_cs may stay high without reg_ack before abort (>=2)
//   TO_W    16       timeout counter width; TO_CYC must fit in TO_W bits
// PORTS
//   app_clk    in   1  sole clock; all logic on rising edge
//   arst_n     in   1  asynchronous, active-low reset
//   cmd_valid  in   1  command offered
//   cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
//   cmd_wr     in   1  1 = write, 0 = read
//   cmd_addr   in   4  register address
//   cmd_wdata  in   8  write data (ignored on reads)
//   rsp_valid  out  1  response available
//   rsp_ready  in   1  response consumed when rsp_valid & rsp_ready
//   rsp_rdata  out  8  read data; 8'h00 for writes; 8'hFF on timeout
//   rsp_err    out  1  1 = bus cycle timed out
//   reg_cs     out  1  bus chip select (registered)
//   reg_wr     out  1  bus write strobe, valid while reg_cs=1
//   reg_addr   out  4  bus address, valid while reg_cs=1
//   reg_wdata  out  8  bus write data, valid while reg_cs=1
//   reg_be     out  1  byte enable; 1 whenever reg_cs=1
//   reg_rdata  in   8  bus read data, sampled on reg_ack
//   reg_ack    in   1  bus acknowledge (single-cycle pulse)
// BEHAVIOUR
//   - Reset (arst_n=0, async): state IDLE; cmd_ready=0 during reset, 1 first cycle
//     after release; rsp_valid=0, rsp_err=0, rsp_rdata=0; reg_cs/wr/be=0,
//     reg_addr=0, reg_wdata=0; timeout counter=0. Reset mid-cycle drops reg_cs at once.
//   - All outputs registered; cmd_ready = (state==IDLE).
//   - FSM: IDLE -> BUS -> RESP -> IDLE.
//   - IDLE: on cmd_valid&cmd_ready latch cmd_wr/addr/wdata into bus regs and set
//     reg_cs=1, reg_be=1 at next edge (accept at cycle N -> reg_cs=1 in N+1). Go BUS.
//   - BUS: reg_cs/wr/addr/wdata/be held stable. Counter increments each BUS cycle
//     without ack.
//     reg_ack=1: rsp_rdata<=reg_wr ? 8'h00 : reg_rdata; rsp_err<=0; reg_cs/wr/be<=0;
//       rsp_valid<=1; counter<=0; go RESP. Ack in cycle K -> rsp_valid=1 in K+1.
//     counter==TO_CYC-1 and no ack: rsp_rdata<=8'hFF; rsp_err<=1; reg_cs/wr/be<=0;
//       rsp_valid<=1; counter<=0; go RESP (reg_cs high exactly TO_CYC cycles).
//     Ack in the timeout cycle: ack wins, rsp_err=0.
//   - RESP: rsp_valid held with stable data until rsp_ready; on handshake
//     rsp_valid<=0, go IDLE. rsp_ready with rsp_valid=0 ignored.
//   - reg_cs low at least 2 cycles (RESP+IDLE) between bus cycles; no back-to-back cs.
//   - reg_ack when reg_cs=0 (IDLE/RESP) ignored; no state or data change.
//   - Counter saturates never: reset to 0 on every exit from BUS.
//   - reg_addr/reg_wdata retain last value after cs drops (only meaningful with cs).
// TESTING
//   - Write: cmd{wr=1,addr=4'h2,wdata=8'hA5}, ack 2 cycles after cs -> reg_cs high
//     2 cycles with wr=1,addr=2,wdata=A5,be=1; rsp_valid next cycle, rdata=00, err=0.
//   - Read: cmd{wr=0,addr=4'h5}, ack same-cycle rdata=8'h3C -> rsp_rdata=3C, err=0,
//     reg_wr=0 throughout; cmd_ready=0 until rsp handshake.
//   - Timeout: TO_CYC=8, never ack -> reg_cs high exactly 8 cycles; rsp_err=1,
//     rsp_rdata=FF; ack at cycle 8 (timeout cycle) -> err=0 and real data returned.
//   - Backpressure: rsp_ready=0 for 10 cycles -> rsp_valid/rdata stable, cmd_ready=0,
//     new cmd_valid not taken; rsp_ready=1 -> IDLE next cycle, cmd accepted after.
//   - Spurious ack in IDLE/RESP -> no response, no state change; cs gap >=2 cycles
//     across back-to-back commands.
//   - Reset assert while reg_cs=1 -> reg_cs, rsp_valid drop asynchronously; after
//     release cmd_ready=1 and a fresh read completes normally.

Source files
------------

// File: rtl/uart_reg_host.sv
// uart_reg_host: reg-bus initiator for the 8-bit UART register interface.
// Takes one command at a time from a valid/ready port, runs a single bus
// cycle (reg_cs held until reg_ack or timeout) and returns the read data
// and error status on a valid/ready response port.
module uart_reg_host #(
    parameter logic [15:0] TO_CYC = 16'd255,  // max cycles reg_cs may wait for ack (>=2)
    parameter int          TO_W   = 16        // timeout counter width
) (
    input  logic       app_clk,
    input  logic       arst_n,
    // command port
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_wr,
    input  logic [3:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    // response port
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    // register bus
    output logic       reg_cs,
    output logic       reg_wr,
    output logic [3:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_be,
    input  logic [7:0] reg_rdata,
    input  logic       reg_ack
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUS  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Last counter value of a bus cycle: reg_cs is high for exactly TO_CYC cycles.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYC - 16'd1);
    localparam logic [TO_W-1:0] CNT_ONE = TO_W'(1);

    logic [1:0]      state_q, state_d;
    logic            ready_q, ready_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [7:0]      rsp_rdata_q, rsp_rdata_d;
    logic            rsp_err_q, rsp_err_d;
    logic            cs_q, cs_d;
    logic            wr_q, wr_d;
    logic [3:0]      addr_q, addr_d;
    logic [7:0]      wdata_q, wdata_d;
    logic            be_q, be_d;
    logic [TO_W-1:0] cnt_q, cnt_d;

    // Next-state logic for the IDLE -> BUS -> RESP -> IDLE sequence.
    always_comb begin
        state_d     = state_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        cs_d        = cs_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        cnt_d       = cnt_q;

        case (state_q)
            ST_IDLE: begin
                // ready_q is low for the first cycle after reset, so no
                // command is taken until cmd_ready has actually been shown.
                if (cmd_valid && ready_q) begin
                    cs_d    = 1'b1;
                    be_d    = 1'b1;
                    wr_d    = cmd_wr;
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    cnt_d   = '0;
                    state_d = ST_BUS;
                end
            end
            ST_BUS: begin
                // An ack arriving in the timeout cycle still wins.
                if (reg_ack) begin
                    rsp_rdata_d = wr_q ? 8'h00 : reg_rdata;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    cs_d        = 1'b0;
                    wr_d        = 1'b0;
                    be_d        = 1'b0;
                    cnt_d       = '0;
                    state_d     = ST_RESP;
                end else if (cnt_q == TO_LAST) begin
                    rsp_rdata_d = 8'hFF;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    cs_d        = 1'b0;
                    wr_d        = 1'b0;
                    be_d        = 1'b0;
                    cnt_d       = '0;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_RESP: begin
                // Response held stable until consumed.
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                cs_d        = 1'b0;
                wr_d        = 1'b0;
                be_d        = 1'b0;
                cnt_d       = '0;
                state_d     = ST_IDLE;
            end
        endcase

        // cmd_ready is a registered copy of "next state is IDLE".
        ready_d = (state_d == ST_IDLE);
    end

    // State and output registers; reset drops the bus cycle immediately.
    always_ff @(posedge app_clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q     <= ST_IDLE;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 8'h00;
            rsp_err_q   <= 1'b0;
            cs_q        <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= 4'h0;
            wdata_q     <= 8'h00;
            be_q        <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            cs_q        <= cs_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            cnt_q       <= cnt_d;
        end
    end

    assign cmd_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign reg_cs    = cs_q;
    assign reg_wr    = wr_q;
    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;
    assign reg_be    = be_q;

endmodule
